// File: rtl/enemy_queue_pkg.sv
// Shared definitions for the enemy spawn sequencer: FSM encoding, queue entry layout,
// terminator type and per-level base-address slots.
package enemy_queue_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWait,
    StIssue,
    StDone
  } state_e;

  localparam int unsigned ENTRY_W  = 15;
  localparam int unsigned TS_MSB   = 14;
  localparam int unsigned TS_LSB   = 3;
  localparam int unsigned TYPE_MSB = 2;
  localparam int unsigned TYPE_LSB = 0;

  localparam logic [2:0] TYPE_END = 3'd0;

  localparam int unsigned LEVEL_TIME_W = 12;

  // Each level owns one QUEUE_DEPTH-sized slot in the queue ROM.
  localparam int unsigned LEVEL1_BASE_SLOT = 0;
  localparam int unsigned LEVEL2_BASE_SLOT = 1;
  localparam int unsigned LEVEL3_BASE_SLOT = 2;

  function automatic int unsigned level_base(input logic [1:0] lvl, input int unsigned depth);
    int unsigned base;
    case (lvl)
      2'd1:    base = LEVEL1_BASE_SLOT * depth;
      2'd2:    base = LEVEL2_BASE_SLOT * depth;
      2'd3:    base = LEVEL3_BASE_SLOT * depth;
      default: base = 0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/level_timer.sv
// 12-bit saturating frame counter; clear has priority over counting.
module level_timer
  import enemy_queue_pkg::*;
(
  input  logic                    clk_25MHz,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    frame_tick,
  output logic [LEVEL_TIME_W-1:0] count
);

  logic [LEVEL_TIME_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && frame_tick && (count_q != '1)) begin
      count_d = count_q + LEVEL_TIME_W'(1);
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/enemy_spawn_sequencer.sv
// Walks a per-level enemy queue ROM and issues timed spawn requests to the allocator.
// Build option: define ENEMY_QUEUE_LOOP_EN to restart a queue at its end instead of finishing.
module enemy_spawn_sequencer
  import enemy_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 64,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk_25MHz,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              start,
  input  logic [1:0]        level,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [14:0]       rom_data,
  output logic              spawn_valid,
  output logic [2:0]        spawn_type,
  input  logic              spawn_ready,
  output logic [11:0]       level_time,
  output logic              queue_done
);

`ifdef ENEMY_QUEUE_LOOP_EN
  localparam bit LoopEn = 1'b1;
`else
  localparam bit LoopEn = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [ENTRY_W-1:0]   entry_q, entry_d;
  logic                 spawn_valid_q, spawn_valid_d;
  logic [2:0]           spawn_type_q, spawn_type_d;
  logic                 queue_done_q, queue_done_d;

  logic                 timer_clear;
  logic                 timer_en;
  logic                 queue_end;
  logic [ADDR_W-1:0]    last_addr;
  logic [2:0]           entry_type;
  logic [11:0]          entry_ts;

  assign last_addr  = base_q + ADDR_W'(QUEUE_DEPTH - 1);
  assign entry_type = entry_q[TYPE_MSB:TYPE_LSB];
  assign entry_ts   = entry_q[TS_MSB:TS_LSB];

  // The level clock runs only while a queue is being worked through.
  assign timer_en = (state_q inside {StFetch, StLoad, StWait, StIssue}) && !pause;

  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    base_d        = base_q;
    entry_d       = entry_q;
    spawn_valid_d = spawn_valid_q;
    spawn_type_d  = spawn_type_q;
    queue_done_d  = queue_done_q;
    timer_clear   = 1'b0;
    queue_end     = 1'b0;

    case (state_q)
      StFetch: state_d = StLoad;
      StLoad: begin
        entry_d = rom_data;
        state_d = StWait;
      end
      StWait: begin
        if (entry_type == TYPE_END) begin
          queue_end = 1'b1;
        end else if (entry_ts <= level_time) begin
          state_d       = StIssue;
          spawn_valid_d = 1'b1;
          spawn_type_d  = entry_type;
        end
      end
      StIssue: begin
        if (spawn_ready) begin
          spawn_valid_d = 1'b0;
          if (rom_addr_q == last_addr) begin
            queue_end = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = StFetch;
          end
        end
      end
      default: ;
    endcase

    if (queue_end) begin
      if (LoopEn) begin
        rom_addr_d  = base_q;
        timer_clear = 1'b1;
        state_d     = StFetch;
      end else begin
        state_d      = StDone;
        queue_done_d = 1'b1;
      end
    end

    // A new start abandons whatever is in flight, including an unacknowledged spawn.
    if (start) begin
      spawn_valid_d = 1'b0;
      queue_done_d  = 1'b0;
      timer_clear   = 1'b1;
      if (level != 2'd0) begin
        base_d     = ADDR_W'(level_base(level, QUEUE_DEPTH));
        rom_addr_d = ADDR_W'(level_base(level, QUEUE_DEPTH));
        state_d    = StFetch;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q       <= StIdle;
      rom_addr_q    <= '0;
      base_q        <= '0;
      entry_q       <= '0;
      spawn_valid_q <= 1'b0;
      spawn_type_q  <= 3'd0;
      queue_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      base_q        <= base_d;
      entry_q       <= entry_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_type_q  <= spawn_type_d;
      queue_done_q  <= queue_done_d;
    end
  end

  level_timer u_level_timer (
    .clk_25MHz  (clk_25MHz),
    .rst        (rst),
    .clear      (timer_clear),
    .enable     (timer_en),
    .frame_tick (frame_tick),
    .count      (level_time)
  );

  assign rom_addr    = rom_addr_q;
  assign spawn_valid = spawn_valid_q;
  assign spawn_type  = spawn_type_q;
  assign queue_done  = queue_done_q;

endmodule

// File: tb/tb_enemy_spawn_sequencer.sv
// Self-checking bench for enemy_spawn_sequencer: vector table, directed corner sequences
// and a randomized run against a queue-level reference model.
module tb_enemy_spawn_sequencer;

  localparam int unsigned QD = 64;
  localparam int unsigned AW = 8;

`ifdef ENEMY_QUEUE_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk_25MHz = 1'b0;
  logic          rst = 1'b1;
  logic          frame_tick = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    level = 2'd0;
  logic          pause = 1'b0;
  logic          spawn_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [14:0]   rom_data;
  logic          spawn_valid;
  logic [2:0]    spawn_type;
  logic [11:0]   level_time;
  logic          queue_done;

  logic [14:0]   rom_mem [256];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  enemy_spawn_sequencer #(
    .QUEUE_DEPTH (QD),
    .ADDR_W      (AW)
  ) dut (
    .clk_25MHz   (clk_25MHz),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .level       (level),
    .pause       (pause),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .spawn_valid (spawn_valid),
    .spawn_type  (spawn_type),
    .spawn_ready (spawn_ready),
    .level_time  (level_time),
    .queue_done  (queue_done)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Synchronous queue ROM: data follows the address by one cycle.
  always_ff @(posedge clk_25MHz) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic [1:0] lv;
    int         ts;
    int         ty;
    int         nticks;
    bit         exp_valid;
    int         exp_ty;
    bit         exp_done;
    int         exp_lt;
    int         exp_addr;
  } vec_t;

  vec_t vecs[8];
  int   q_ts[$];
  int   q_ty[$];
  int   hs_cyc[$];
  int   hs_ty[$];

  task automatic step();
    @(negedge clk_25MHz);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = 15'd0;
  endtask

  function automatic logic [14:0] ent(input int ts, input int ty);
    return {12'(ts), 3'(ty)};
  endfunction

  function automatic int sat(input int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic do_start(input logic [1:0] lv);
    start = 1'b1;
    level = lv;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int k = 0;
    while (!spawn_valid && k < budget) begin
      step();
      k++;
    end
    chk(nm, 32'(spawn_valid), 32'd1);
  endtask

  initial begin
    int hs, k, base, n, t, idx, last_hs, model_lt, hold_ty;
    bit was_pending;
    logic [1:0] lvr;

    vecs[0] = '{2'd1, 0, 2, 0, 1'b1, 2, 1'b0, 0, 0};
    vecs[1] = '{2'd1, 5, 1, 4, 1'b0, 0, 1'b0, 4, 0};
    vecs[2] = '{2'd1, 5, 1, 5, 1'b1, 1, 1'b0, 5, 0};
    vecs[3] = '{2'd2, 3, 7, 2, 1'b0, 0, 1'b0, 2, 64};
    vecs[4] = '{2'd2, 3, 7, 3, 1'b1, 7, 1'b0, 3, 64};
    vecs[5] = '{2'd3, 0, 0, 0, 1'b0, 0, !LOOP, 0, 128};
    vecs[6] = '{2'd3, 10, 4, 12, 1'b1, 4, 1'b0, 12, 128};
    vecs[7] = '{2'd0, 0, 1, 3, 1'b0, 0, 1'b0, 0, 128};

    clear_rom();

    // Reset wins over a simultaneous start.
    start = 1'b1;
    level = 2'd1;
    step();
    step();
    chk("reset rom_addr", 32'(rom_addr), 0);
    chk("reset spawn_valid", 32'(spawn_valid), 0);
    chk("reset spawn_type", 32'(spawn_type), 0);
    chk("reset level_time", 32'(level_time), 0);
    chk("reset queue_done", 32'(queue_done), 0);
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("idle after reset", 32'(spawn_valid), 0);

    foreach (vecs[v]) begin
      clear_rom();
      if (vecs[v].lv != 2'd0) begin
        rom_mem[(int'(vecs[v].lv) - 1) * QD] = ent(vecs[v].ts, vecs[v].ty);
      end
      spawn_ready = 1'b0;
      do_start(vecs[v].lv);
      repeat (4) step();
      for (int i = 0; i < vecs[v].nticks; i++) begin
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
      end
      repeat (3) step();
      chk($sformatf("vec%0d spawn_valid", v), 32'(spawn_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) begin
        chk($sformatf("vec%0d spawn_type", v), 32'(spawn_type), 32'(vecs[v].exp_ty));
      end
      chk($sformatf("vec%0d queue_done", v), 32'(queue_done), 32'(vecs[v].exp_done));
      chk($sformatf("vec%0d level_time", v), 32'(level_time), 32'(vecs[v].exp_lt));
      chk($sformatf("vec%0d rom_addr", v), 32'(rom_addr), 32'(vecs[v].exp_addr));
    end

    // First-spawn latency from start.
    clear_rom();
    rom_mem[0] = ent(0, 2);
    do_start(2'd1);
    chk("lat rom_addr c1", 32'(rom_addr), 0);
    chk("lat valid c1", 32'(spawn_valid), 0);
    step();
    step();
    chk("lat valid c3", 32'(spawn_valid), 0);
    step();
    chk("lat valid c4", 32'(spawn_valid), 1);
    chk("lat type c4", 32'(spawn_type), 2);

    // Spawn waits for its timestamp even with ready held high.
    clear_rom();
    rom_mem[0] = ent(5, 1);
    spawn_ready = 1'b1;
    do_start(2'd1);
    for (int i = 0; i < 5; i++) begin
      chk("ts5 early valid", 32'(spawn_valid), 0);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    chk("ts5 level_time", 32'(level_time), 5);
    wait_valid("ts5 valid", 4);
    chk("ts5 type", 32'(spawn_type), 1);
    spawn_ready = 1'b0;

    // Backpressure then back-to-back spawns.
    clear_rom();
    for (int i = 0; i < 3; i++) rom_mem[i] = ent(3, i + 1);
    do_start(2'd1);
    frame_tick = 1'b1;
    repeat (3) step();
    frame_tick = 1'b0;
    wait_valid("b2b first valid", 10);
    for (int i = 0; i < 10; i++) begin
      chk("b2b hold valid", 32'(spawn_valid), 1);
      chk("b2b hold type", 32'(spawn_type), 1);
      step();
    end
    spawn_ready = 1'b1;
    hs_cyc.delete();
    hs_ty.delete();
    for (int i = 0; i < 40; i++) begin
      if (spawn_valid) begin
        hs_cyc.push_back(cyc);
        hs_ty.push_back(int'(spawn_type));
      end
      step();
    end
    spawn_ready = 1'b0;
    chk("b2b handshakes", 32'(hs_cyc.size()), 3);
    if (hs_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("b2b type order", 32'(hs_ty[i]), 32'(i + 1));
      chk("b2b gap 1", 32'(hs_cyc[1] - hs_cyc[0]), 4);
      chk("b2b gap 2", 32'(hs_cyc[2] - hs_cyc[1]), 4);
    end
    chk("b2b queue_done", 32'(queue_done), 32'(!LOOP));

    // Level 2 queue with explicit terminator.
    clear_rom();
    rom_mem[64] = ent(1, 3);
    rom_mem[65] = ent(0, 0);
    do_start(2'd2);
    chk("l2 rom_addr base", 32'(rom_addr), 64);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    spawn_ready = 1'b1;
    wait_valid("l2 valid", 10);
    chk("l2 type", 32'(spawn_type), 3);
    step();
    spawn_ready = 1'b0;
    chk("l2 rom_addr next", 32'(rom_addr), 65);
    chk("l2 valid dropped", 32'(spawn_valid), 0);
    repeat (5) step();
    chk("l2 queue_done", 32'(queue_done), 32'(!LOOP));
    chk("l2 rom_addr end", 32'(rom_addr), LOOP ? 32'd64 : 32'd65);

    // Restart while a spawn is pending.
    clear_rom();
    rom_mem[0] = ent(0, 5);
    rom_mem[128] = ent(9, 6);
    do_start(2'd1);
    wait_valid("restart valid", 10);
    frame_tick = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    chk("restart lt before", 32'(level_time), 2);
    chk("restart type before", 32'(spawn_type), 5);
    do_start(2'd3);
    chk("restart valid", 32'(spawn_valid), 0);
    chk("restart rom_addr", 32'(rom_addr), 128);
    chk("restart level_time", 32'(level_time), 0);
    chk("restart queue_done", 32'(queue_done), 0);

    // Reset mid-run overrides a coincident start.
    rst = 1'b1;
    start = 1'b1;
    level = 2'd2;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("rst+start rom_addr", 32'(rom_addr), 0);
    chk("rst+start level_time", 32'(level_time), 0);
    chk("rst+start spawn_type", 32'(spawn_type), 0);

    // Pause freezes the clock; release saturates it.
    clear_rom();
    rom_mem[0] = ent(4095, 1);
    do_start(2'd1);
    pause = 1'b1;
    frame_tick = 1'b1;
    repeat (4200) step();
    chk("pause frozen", 32'(level_time), 0);
    pause = 1'b0;
    repeat (100) step();
    chk("release count", 32'(level_time), 100);
    repeat (4900) step();
    frame_tick = 1'b0;
    chk("saturate", 32'(level_time), 4095);
    chk("ts 4095 valid", 32'(spawn_valid), 1);

    // Full queue with no terminator ends at its last slot.
    clear_rom();
    for (int i = 0; i < 64; i++) rom_mem[i] = ent(0, (i % 7) + 1);
    do_start(2'd1);
    spawn_ready = 1'b1;
    hs = 0;
    k = 0;
    while (hs < 64 && k < 64 * 5 + 40) begin
      if (spawn_valid) begin
        chk("full type", 32'(spawn_type), 32'((hs % 7) + 1));
        hs++;
      end
      step();
      k++;
    end
    spawn_ready = 1'b0;
    chk("full handshakes", 32'(hs), 64);
    repeat (5) step();
    chk("full queue_done", 32'(queue_done), 32'(!LOOP));
    chk("full rom_addr", 32'(rom_addr), LOOP ? 32'd0 : 32'd63);
    chk("full valid after", 32'(spawn_valid), 32'(LOOP));

    // Randomized queues against the reference model.
    for (int r = 0; r < 6; r++) begin
      clear_rom();
      lvr = 2'($urandom_range(1, 3));
      base = (int'(lvr) - 1) * QD;
      n = $urandom_range(1, 8);
      t = 0;
      q_ts.delete();
      q_ty.delete();
      for (int i = 0; i < n; i++) begin
        t += $urandom_range(0, 3);
        q_ts.push_back(t);
        q_ty.push_back($urandom_range(1, 7));
        rom_mem[base + i] = ent(t, q_ty[i]);
      end
      frame_tick = 1'b0;
      pause = 1'b0;
      spawn_ready = 1'b0;
      do_start(lvr);
      model_lt = 0;
      idx = 0;
      last_hs = -100;
      k = 0;
      was_pending = 1'b0;
      hold_ty = 0;
      while (idx < n && k < 3000) begin
        chk("rand level_time", 32'(level_time), 32'(sat(model_lt)));
        if (was_pending) begin
          chk("rand valid held", 32'(spawn_valid), 1);
          chk("rand type stable", 32'(spawn_type), 32'(hold_ty));
        end
        spawn_ready = 1'($urandom_range(0, 1));
        frame_tick = ($urandom_range(0, 2) == 0);
        pause = ($urandom_range(0, 3) == 0);
        was_pending = spawn_valid && !spawn_ready;
        hold_ty = int'(spawn_type);
        if (spawn_valid && spawn_ready) begin
          chk("rand spawn type", 32'(spawn_type), 32'(q_ty[idx]));
          chk("rand ts reached", 32'(q_ts[idx] <= int'(level_time)), 1);
          chk("rand spacing", 32'((cyc - last_hs) >= 4), 1);
          last_hs = cyc;
          idx++;
        end
        if (frame_tick && !pause) model_lt++;
        step();
        k++;
      end
      frame_tick = 1'b0;
      pause = 1'b0;
      spawn_ready = 1'b0;
      chk("rand all issued", 32'(idx), 32'(n));
      repeat (8) step();
      chk("rand queue_done", 32'(queue_done), 32'(!LOOP));
      chk("rand end level_time", 32'(level_time), LOOP ? 32'd0 : 32'(sat(model_lt)));
      chk("rand end rom_addr", 32'(rom_addr), LOOP ? 32'(base) : 32'(base + n));
      chk("rand end valid", 32'(spawn_valid), 32'(LOOP && q_ts[0] == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
